audio_frame_buffer: RTL and testbench

- Producer-side frame buffer feeding the FFT controller's read interface (`r_req` / `buf_almost_rfull` / `buf_rempty`).
- Accepts a non-stallable sample stream from the front-end (pre-emphasis) into a circular RAM.
- Presents overlapping frames of N_FFT samples, hop HOP, to the FFT controller.
- Returns read data one cycle after each accepted `r_req`, aligned with the controller's `valid`.

---
 rtl/audio_frame_buffer.sv | 123 ++++++++++++
 tb/tb_audio_frame_buffer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_buffer.sv
// Circular sample buffer serving overlapping N_FFT-sample frames (hop HOP) to the FFT controller; AUDIO_FRAME_BUF_DROP_CNT_EN adds drop_cnt.
// Latency: r_data valid one cycle after an accepted r_req; flags are combinational from pointer state.
// Backpressure: input stream cannot be stalled, so samples arriving while full are dropped and flagged; reads are refused while buf_rempty.
module audio_frame_buffer #(
    parameter int N_FFT      = 256,
    parameter int HOP        = 128,
    parameter int DEPTH      = 512,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_en_inf_system_sync,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  r_req,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  buf_almost_rfull,
    output logic                  buf_rempty,
    output logic                  buf_full,
    output logic                  ovf_flag
`ifdef AUDIO_FRAME_BUF_DROP_CNT_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(N_FFT) + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] NFFT_P  = PW'(N_FFT);
    localparam logic [PW-1:0] HOP_P   = PW'(HOP);
    localparam logic [CW-1:0] NFFT_C  = CW'(N_FFT);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] frame_start;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] rd_cnt;

    logic [PW-1:0] fill;
    logic [PW-1:0] unread;
    logic          frame_release;
    logic          wr_en;
    logic          drop;
    logic          rd_en;
    logic          en;

    assign en            = spi_en_inf_system_sync;
    assign fill          = wr_ptr - frame_start;
    assign unread        = wr_ptr - rd_ptr;
    assign frame_release = (rd_cnt == NFFT_C);

    assign buf_full         = (fill == DEPTH_P);
    assign buf_rempty       = frame_release || (unread == '0);
    assign buf_almost_rfull = (fill >= NFFT_P) && (rd_cnt == '0);

    // Overflow check uses pre-release fill, so a write on the release edge may still drop.
    assign wr_en = en && in_valid && !buf_full;
    assign drop  = en && in_valid && buf_full;
    assign rd_en = en && r_req && !buf_rempty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            frame_start <= '0;
            rd_ptr      <= '0;
            rd_cnt      <= '0;
            ovf_flag    <= 1'b0;
        end else if (!en) begin
            wr_ptr      <= '0;
            frame_start <= '0;
            rd_ptr      <= '0;
            rd_cnt      <= '0;
            ovf_flag    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drop) begin
                ovf_flag <= 1'b1;
            end
            // Rewind to the next frame start so consecutive frames overlap by N_FFT-HOP.
            if (frame_release) begin
                frame_start <= frame_start + HOP_P;
                rd_ptr      <= frame_start + HOP_P;
                rd_cnt      <= '0;
            end else if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Storage array: no reset so it maps onto a 1R1W SRAM macro.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (rd_en) begin
            r_data <= mem[rd_ptr[AW-1:0]];
        end
    end

`ifdef AUDIO_FRAME_BUF_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (!en) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Scoreboard bench for audio_frame_buffer: reads push expected samples, r_data pops them a cycle later.
module tb_audio_frame_buffer;

    localparam int N_FFT = 256;
    localparam int HOP   = 128;
    localparam int DEPTH = 512;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          spi_en_inf_system_sync;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          r_req;
    logic [DW-1:0] r_data;
    logic          buf_almost_rfull;
    logic          buf_rempty;
    logic          buf_full;
    logic          ovf_flag;
`ifdef AUDIO_FRAME_BUF_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    audio_frame_buffer #(
        .N_FFT(N_FFT), .HOP(HOP), .DEPTH(DEPTH), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .spi_en_inf_system_sync(spi_en_inf_system_sync),
        .in_valid(in_valid),
        .in_data(in_data),
        .r_req(r_req),
        .r_data(r_data),
        .buf_almost_rfull(buf_almost_rfull),
        .buf_rempty(buf_rempty),
        .buf_full(buf_full),
        .ovf_flag(ovf_flag)
`ifdef AUDIO_FRAME_BUF_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // Reference model in absolute sample indices since the last flush.
    logic [DW-1:0] sdata [8192];
    logic [DW-1:0] exp_q [$];
    int            m_wr, m_fs, m_rd, m_cnt, m_drop;
    logic          m_ovf;
    logic [DW-1:0] m_rdata;

    task automatic model_clear(input logic clr_rdata);
        m_wr = 0; m_fs = 0; m_rd = 0; m_cnt = 0; m_drop = 0; m_ovf = 1'b0;
        exp_q.delete();
        if (clr_rdata) m_rdata = '0;
    endtask

    // One clock: check flags, drive inputs, advance the model, then check r_data.
    task automatic cycle(input logic en, input logic v, input logic [DW-1:0] d,
                         input logic req, output logic acc);
        int   fill, unread;
        logic rel, rempty, full, arf;
        fill   = m_wr - m_fs;
        unread = m_wr - m_rd;
        rel    = (m_cnt == N_FFT);
        rempty = rel || (unread == 0);
        full   = (fill == DEPTH);
        arf    = (fill >= N_FFT) && (m_cnt == 0);
        vectors++;
        if ({buf_almost_rfull, buf_rempty, buf_full, ovf_flag} !== {arf, rempty, full, m_ovf}) begin
            fails++;
            $display("FAIL flags t=%0t arf/rempty/full/ovf got %b%b%b%b want %b%b%b%b", $time,
                     buf_almost_rfull, buf_rempty, buf_full, ovf_flag, arf, rempty, full, m_ovf);
        end
`ifdef AUDIO_FRAME_BUF_DROP_CNT_EN
        vectors++;
        if (drop_cnt !== 8'(m_drop)) begin
            fails++;
            $display("FAIL drop_cnt t=%0t got %0d want %0d", $time, drop_cnt, m_drop);
        end
`endif
        spi_en_inf_system_sync = en;
        in_valid = v;
        in_data  = d;
        r_req    = req;
        acc      = 1'b0;
        if (!en) begin
            model_clear(1'b0);
        end else begin
            if (v) begin
                if (!full) begin
                    sdata[m_wr] = d;
                    m_wr++;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (rel) begin
                m_fs += HOP;
                m_rd  = m_fs;
                m_cnt = 0;
            end else if (req && !rempty) begin
                exp_q.push_back(sdata[m_rd]);
                m_rd++;
                m_cnt++;
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
        vectors++;
        if (r_data !== m_rdata) begin
            fails++;
            $display("FAIL r_data t=%0t got %0d want %0d", $time, r_data, m_rdata);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        spi_en_inf_system_sync = 1'b0;
        in_valid = 1'b0; in_data = '0; r_req = 1'b0;
        model_clear(1'b1);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({r_data, buf_almost_rfull, buf_rempty, buf_full, ovf_flag} !== {16'd0, 4'b0100}) begin
            fails++;
            $display("FAIL reset_state got r_data=%0d flags=%b%b%b%b want 0 0100", r_data,
                     buf_almost_rfull, buf_rempty, buf_full, ovf_flag);
        end
        rst = 1'b0;
    endtask

    task automatic test_empty_read;
        logic acc;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1, acc);
            vectors++;
            if (acc !== 1'b0 || r_data !== 16'd0 || buf_rempty !== 1'b1) begin
                fails++;
                $display("FAIL empty_read cyc %0d got r_data=%0d rempty=%b want 0 1", i, r_data, buf_rempty);
            end
        end
    endtask

    task automatic test_fill_read;
        logic acc;
        int   n;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 1'b1, 16'(i), 1'b0, acc);
            if (i == 254 || i == 255) begin
                vectors++;
                if (buf_almost_rfull !== (i == 255)) begin
                    fails++;
                    $display("FAIL almost_rfull after %0d writes got %b want %b", i + 1, buf_almost_rfull, i == 255);
                end
            end
        end
        for (int i = 0; i < 256; i++) cycle(1'b1, 1'b0, '0, 1'b1, acc);
        vectors++;
        if (r_data !== 16'd255 || buf_rempty !== 1'b1) begin
            fails++;
            $display("FAIL frame0_end got r_data=%0d rempty=%b want 255 1", r_data, buf_rempty);
        end
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        vectors++;
        if (acc !== 1'b0 || r_data !== 16'd255) begin
            fails++;
            $display("FAIL release_cycle got r_data=%0d want 255 (request must be ignored)", r_data);
        end
        n = 0;
        for (int i = 0; i < 180 && n < 172; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1, acc);
            if (acc) n++;
            if (acc && n == 1) begin
                vectors++;
                if (r_data !== 16'd128) begin
                    fails++;
                    $display("FAIL frame1_first got %0d want 128", r_data);
                end
            end
        end
        vectors++;
        if (r_data !== 16'd299 || buf_rempty !== 1'b1 || n != 172) begin
            fails++;
            $display("FAIL frame1_drain got r_data=%0d rempty=%b reads=%0d want 299 1 172", r_data, buf_rempty, n);
        end
    endtask

    task automatic test_overflow;
        logic acc;
        cycle(1'b0, 1'b0, '0, 1'b0, acc);
        for (int i = 0; i < 520; i++) cycle(1'b1, 1'b1, 16'(i), 1'b0, acc);
        vectors++;
        if (buf_full !== 1'b1 || ovf_flag !== 1'b1) begin
            fails++;
            $display("FAIL overflow got full=%b ovf=%b want 1 1", buf_full, ovf_flag);
        end
`ifdef AUDIO_FRAME_BUF_DROP_CNT_EN
        vectors++;
        if (drop_cnt !== 8'd8) begin
            fails++;
            $display("FAIL drop_cnt_8 got %0d want 8", drop_cnt);
        end
`endif
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        vectors++;
        if (r_data !== 16'd0) begin
            fails++;
            $display("FAIL overflow_first_read got %0d want 0", r_data);
        end
    endtask

    task automatic test_concurrent;
        logic acc;
        logic reading;
        int   frames, got, ncyc, wcnt;
        cycle(1'b0, 1'b0, '0, 1'b0, acc);
        reading = 1'b0; frames = 0; got = 0; ncyc = 0; wcnt = 0;
        while (frames < 10 && ncyc < 20000) begin
            if (!reading && buf_almost_rfull) reading = 1'b1;
            cycle(1'b1, (ncyc % 3) == 0, 16'(wcnt), reading, acc);
            if ((ncyc % 3) == 0) wcnt++;
            ncyc++;
            if (acc) begin
                got++;
                if (got == N_FFT) begin
                    vectors++;
                    if (r_data !== 16'(HOP * frames + N_FFT - 1)) begin
                        fails++;
                        $display("FAIL stream_frame%0d_last got %0d want %0d", frames, r_data, HOP * frames + N_FFT - 1);
                    end
                    frames++;
                    got = 0;
                    reading = 1'b0;
                end
            end
        end
        vectors++;
        if (frames != 10) begin
            fails++;
            $display("FAIL stream_timeout got %0d frames want 10", frames);
        end
    endtask

    task automatic test_flush_mid;
        logic acc;
        int   n;
        cycle(1'b0, 1'b0, '0, 1'b0, acc);
        for (int i = 0; i < 256; i++) cycle(1'b1, 1'b1, 16'(5000 + i), 1'b0, acc);
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, '0, 1'b1, acc);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 16'hDEAD, 1'b1, acc);
        vectors++;
        if (r_data !== 16'd5099 || buf_rempty !== 1'b1 || buf_almost_rfull !== 1'b0) begin
            fails++;
            $display("FAIL flush_hold got r_data=%0d rempty=%b arf=%b want 5099 1 0", r_data, buf_rempty, buf_almost_rfull);
        end
        for (int i = 0; i < 256; i++) cycle(1'b1, 1'b1, 16'(7000 + i), 1'b0, acc);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1, acc);
            if (acc) n++;
            if (i == 0) begin
                vectors++;
                if (r_data !== 16'd7000) begin
                    fails++;
                    $display("FAIL flush_first got %0d want 7000", r_data);
                end
            end
        end
        vectors++;
        if (r_data !== 16'd7255 || n != 256) begin
            fails++;
            $display("FAIL flush_last got %0d reads=%0d want 7255 256", r_data, n);
        end
    endtask

    task automatic test_async_reset;
        logic acc;
        cycle(1'b0, 1'b0, '0, 1'b0, acc);
        for (int i = 0; i < 520; i++) cycle(1'b1, 1'b1, 16'(100 + i), 1'b0, acc);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1, acc);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({r_data, buf_almost_rfull, buf_rempty, buf_full, ovf_flag} !== {16'd0, 4'b0100}) begin
            fails++;
            $display("FAIL async_reset got r_data=%0d flags=%b%b%b%b want 0 0100", r_data,
                     buf_almost_rfull, buf_rempty, buf_full, ovf_flag);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear(1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
    endtask

    initial begin
        test_reset();
        test_empty_read();
        test_fill_read();
        test_overflow();
        test_concurrent();
        test_flush_mid();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
